// File: rtl/serial_data_compare_if.sv
// Operand/result handshake bundle for serial_data_compare.
// The slave side is the comparator; the master side is the producer/consumer pair.
interface serial_data_compare_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIGIT = 4
);
   localparam int unsigned CntW = $clog2(WIDTH / DIGIT + 1);

   logic             iValid;
   logic             oReady;
   logic [WIDTH-1:0] iData_a;
   logic [WIDTH-1:0] iData_b;
   logic             iSigned;
   logic             oValid;
   logic             iReady;
   logic [2:0]       oData;
   logic [CntW-1:0]  oDigits;

   modport slave (
      input  iValid, iData_a, iData_b, iSigned, iReady,
      output oReady, oValid, oData, oDigits
   );

   modport master (
      output iValid, iData_a, iData_b, iSigned, iReady,
      input  oReady, oValid, oData, oDigits
   );
endinterface

// File: rtl/serial_data_compare.sv
// Digit-serial magnitude comparator: scans DIGIT bits per cycle from the MSB and
// stops at the first differing digit; signed compare via sign-bit inversion.
module serial_data_compare #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIGIT = 4
) (
   input logic                  iClk,
   input logic                  iRst_n,
   serial_data_compare_if.slave bus_io
);
   localparam int unsigned N    = WIDTH / DIGIT;
   localparam int unsigned CntW = $clog2(N + 1);

   typedef enum logic [1:0] {StIdle, StCmp, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [CntW-1:0]  digits_q, digits_d;
   logic [2:0]       data_q, data_d;
   logic [DIGIT-1:0] a_dig, b_dig;
   logic [WIDTH-1:0] sign_flip;

   // Flipping the sign bit of both operands maps two's-complement order onto unsigned order.
   assign sign_flip = WIDTH'(bus_io.iSigned) << (WIDTH - 1);

   // Operands shift left as digits match, so the digit under test is always the top one.
   assign a_dig = a_q[WIDTH-1 -: DIGIT];
   assign b_dig = b_q[WIDTH-1 -: DIGIT];

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      cnt_d    = cnt_q;
      digits_d = digits_q;
      data_d   = data_q;
      unique case (state_q)
         StIdle: begin
            if (bus_io.iValid) begin
               a_d     = bus_io.iData_a ^ sign_flip;
               b_d     = bus_io.iData_b ^ sign_flip;
               cnt_d   = '0;
               state_d = StCmp;
            end
         end
         StCmp: begin
            cnt_d = cnt_q + 1'b1;
            if (a_dig > b_dig) begin
               data_d   = 3'b100;
               digits_d = cnt_d;
               state_d  = StDone;
            end else if (a_dig < b_dig) begin
               data_d   = 3'b001;
               digits_d = cnt_d;
               state_d  = StDone;
            end else if (cnt_q == CntW'(N - 1)) begin
               data_d   = 3'b010;
               digits_d = cnt_d;
               state_d  = StDone;
            end else begin
               a_d = a_q << DIGIT;
               b_d = b_q << DIGIT;
            end
         end
         StDone: begin
            if (bus_io.iReady) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         state_q  <= StIdle;
         a_q      <= '0;
         b_q      <= '0;
         cnt_q    <= '0;
         digits_q <= '0;
         data_q   <= 3'b000;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         cnt_q    <= cnt_d;
         digits_q <= digits_d;
         data_q   <= data_d;
      end
   end

   assign bus_io.oReady  = (state_q == StIdle);
   assign bus_io.oValid  = (state_q == StDone);
   assign bus_io.oData   = data_q;
   assign bus_io.oDigits = digits_q;
endmodule

// File: tb/tb_serial_data_compare.sv
// Directed and randomised checks of serial_data_compare at 8/4, 16/4 and 4/4 geometries.
module tb_serial_data_compare;
   logic clk = 1'b0;
   logic rst8_n;
   logic rst16_n;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   serial_data_compare_if #(.WIDTH(8), .DIGIT(4))  if8 ();
   serial_data_compare_if #(.WIDTH(16), .DIGIT(4)) if16 ();
   serial_data_compare_if #(.WIDTH(4), .DIGIT(4))  if4 ();

   serial_data_compare #(.WIDTH(8), .DIGIT(4)) dut8 (
      .iClk   (clk),
      .iRst_n (rst8_n),
      .bus_io (if8)
   );
   serial_data_compare #(.WIDTH(16), .DIGIT(4)) dut16 (
      .iClk   (clk),
      .iRst_n (rst16_n),
      .bus_io (if16)
   );
   serial_data_compare #(.WIDTH(4), .DIGIT(4)) dut4 (
      .iClk   (clk),
      .iRst_n (rst8_n),
      .bus_io (if4)
   );

   // Launch one operation on the 8-bit DUT, scramble the inputs after accept,
   // and return the cycle count from the accept edge to oValid.
   task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                       output int lat, output logic [2:0] data, output logic [1:0] dig);
      @(negedge clk);
      if8.iValid  = 1'b1;
      if8.iData_a = a;
      if8.iData_b = b;
      if8.iSigned = s;
      @(posedge clk);
      #1;
      if8.iValid  = 1'b0;
      if8.iData_a = 8'($urandom);
      if8.iData_b = 8'($urandom);
      if8.iSigned = 1'($urandom);
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end while (!if8.oValid && lat < 20);
      data = if8.oData;
      dig  = if8.oDigits;
   endtask

   task automatic take8();
      @(negedge clk);
      if8.iReady = 1'b1;
      @(negedge clk);
      if8.iReady = 1'b0;
   endtask

   task automatic test_reset();
      rst8_n  = 1'b0;
      rst16_n = 1'b0;
      {if8.iValid, if8.iReady, if8.iSigned, if8.iData_a, if8.iData_b} = '0;
      {if16.iValid, if16.iReady, if16.iSigned, if16.iData_a, if16.iData_b} = '0;
      {if4.iValid, if4.iReady, if4.iSigned, if4.iData_a, if4.iData_b} = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({if8.oReady, if8.oValid, if8.oData, if8.oDigits} !== {1'b1, 1'b0, 3'b000, 2'd0}) begin
         errors++;
         $display("FAIL reset8 got rdy=%b vld=%b data=%b dig=%0d want 1 0 000 0",
                  if8.oReady, if8.oValid, if8.oData, if8.oDigits);
      end
      checks++;
      if ({if16.oReady, if16.oValid, if16.oData, if16.oDigits} !== {1'b1, 1'b0, 3'b000, 3'd0})
      begin
         errors++;
         $display("FAIL reset16 got rdy=%b vld=%b data=%b dig=%0d want 1 0 000 0",
                  if16.oReady, if16.oValid, if16.oData, if16.oDigits);
      end
      rst8_n  = 1'b1;
      rst16_n = 1'b1;
   endtask

   task automatic test_unsigned();
      int lat; logic [2:0] d; logic [1:0] g;
      run8(8'h3C, 8'h3C, 1'b0, lat, d, g);
      checks++;
      if ({lat, d, g} !== {32'd2, 3'b010, 2'd2}) begin
         errors++;
         $display("FAIL eq_3C got lat=%0d data=%b dig=%0d want 2 010 2", lat, d, g);
      end
      take8();
      run8(8'hA0, 8'h5F, 1'b0, lat, d, g);
      checks++;
      if ({lat, d, g} !== {32'd1, 3'b100, 2'd1}) begin
         errors++;
         $display("FAIL uns_A0_5F got lat=%0d data=%b dig=%0d want 1 100 1", lat, d, g);
      end
      take8();
   endtask

   task automatic test_signed();
      int lat; logic [2:0] d; logic [1:0] g;
      run8(8'hA0, 8'h5F, 1'b1, lat, d, g);
      checks++;
      if ({lat, d, g} !== {32'd1, 3'b001, 2'd1}) begin
         errors++;
         $display("FAIL sgn_A0_5F got lat=%0d data=%b dig=%0d want 1 001 1", lat, d, g);
      end
      take8();
      run8(8'hFF, 8'hFE, 1'b1, lat, d, g);
      checks++;
      if ({lat, d, g} !== {32'd2, 3'b100, 2'd2}) begin
         errors++;
         $display("FAIL sgn_FF_FE got lat=%0d data=%b dig=%0d want 2 100 2", lat, d, g);
      end
      take8();
      run8(8'h80, 8'h7F, 1'b1, lat, d, g);
      checks++;
      if ({lat, d, g} !== {32'd1, 3'b001, 2'd1}) begin
         errors++;
         $display("FAIL sgn_80_7F got lat=%0d data=%b dig=%0d want 1 001 1", lat, d, g);
      end
      take8();
   endtask

   task automatic test_backpressure();
      int lat; logic [2:0] d; logic [1:0] g;
      run8(8'h3C, 8'h3C, 1'b0, lat, d, g);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if ({if8.oValid, if8.oReady, if8.oData, if8.oDigits} !== {1'b1, 1'b0, 3'b010, 2'd2})
         begin
            errors++;
            $display("FAIL hold%0d got vld=%b rdy=%b data=%b dig=%0d want 1 0 010 2", i,
                     if8.oValid, if8.oReady, if8.oData, if8.oDigits);
         end
      end
      if8.iReady = 1'b1;
      @(negedge clk);
      if8.iReady = 1'b0;
      checks++;
      if ({if8.oValid, if8.oReady, if8.oData, if8.oDigits} !== {1'b0, 1'b1, 3'b010, 2'd2}) begin
         errors++;
         $display("FAIL release got vld=%b rdy=%b data=%b dig=%0d want 0 1 010 2",
                  if8.oValid, if8.oReady, if8.oData, if8.oDigits);
      end
   endtask

   task automatic test_busy_ignore();
      @(negedge clk);
      if8.iValid  = 1'b1;
      if8.iData_a = 8'h10;
      if8.iData_b = 8'h20;
      if8.iSigned = 1'b0;
      @(posedge clk);
      #1;
      if8.iData_a = 8'h20;
      if8.iData_b = 8'h10;
      repeat (4) @(negedge clk);
      checks++;
      if ({if8.oValid, if8.oReady, if8.oData, if8.oDigits} !== {1'b1, 1'b0, 3'b001, 2'd1}) begin
         errors++;
         $display("FAIL busy_hold got vld=%b rdy=%b data=%b dig=%0d want 1 0 001 1",
                  if8.oValid, if8.oReady, if8.oData, if8.oDigits);
      end
      if8.iReady = 1'b1;
      @(negedge clk);
      if8.iReady = 1'b0;
      checks++;
      if ({if8.oValid, if8.oReady} !== 2'b01) begin
         errors++;
         $display("FAIL busy_exit got vld=%b rdy=%b want 0 1", if8.oValid, if8.oReady);
      end
      @(negedge clk);
      if8.iValid = 1'b0;
      @(negedge clk);
      checks++;
      if ({if8.oValid, if8.oData, if8.oDigits} !== {1'b1, 3'b100, 2'd1}) begin
         errors++;
         $display("FAIL busy_next got vld=%b data=%b dig=%0d want 1 100 1",
                  if8.oValid, if8.oData, if8.oDigits);
      end
      take8();
   endtask

   task automatic test_reset_mid_op();
      int lat;
      @(negedge clk);
      if16.iValid  = 1'b1;
      if16.iData_a = 16'h1234;
      if16.iData_b = 16'h1235;
      if16.iSigned = 1'b0;
      @(posedge clk);
      #1;
      if16.iValid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst16_n = 1'b0;
      @(negedge clk);
      rst16_n = 1'b1;
      checks++;
      if ({if16.oValid, if16.oReady, if16.oData, if16.oDigits} !== {1'b0, 1'b1, 3'b000, 3'd0})
      begin
         errors++;
         $display("FAIL midrst got vld=%b rdy=%b data=%b dig=%0d want 0 1 000 0",
                  if16.oValid, if16.oReady, if16.oData, if16.oDigits);
      end
      repeat (5) @(negedge clk);
      checks++;
      if (if16.oValid !== 1'b0) begin
         errors++;
         $display("FAIL midrst_quiet got vld=%b want 0", if16.oValid);
      end
      if16.iValid = 1'b1;
      @(posedge clk);
      #1;
      if16.iValid = 1'b0;
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end while (!if16.oValid && lat < 20);
      checks++;
      if ({lat, if16.oData, if16.oDigits} !== {32'd4, 3'b001, 3'd4}) begin
         errors++;
         $display("FAIL fresh16 got lat=%0d data=%b dig=%0d want 4 001 4",
                  lat, if16.oData, if16.oDigits);
      end
      if16.iReady = 1'b1;
      @(negedge clk);
      if16.iReady = 1'b0;
   endtask

   task automatic test_width_eq_digit();
      logic [3:0] av [2] = '{4'h3, 4'h8};
      logic [3:0] bv [2] = '{4'h3, 4'h7};
      logic       sv [2] = '{1'b0, 1'b1};
      logic [2:0] ev [2] = '{3'b010, 3'b001};
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         if4.iValid  = 1'b1;
         if4.iData_a = av[i];
         if4.iData_b = bv[i];
         if4.iSigned = sv[i];
         @(negedge clk);
         if4.iValid = 1'b0;
         @(negedge clk);
         checks++;
         if ({if4.oValid, if4.oData, if4.oDigits} !== {1'b1, ev[i], 1'b1}) begin
            errors++;
            $display("FAIL w4_%0d got vld=%b data=%b dig=%0d want 1 %b 1", i,
                     if4.oValid, if4.oData, if4.oDigits, ev[i]);
         end
         if4.iReady = 1'b1;
         @(negedge clk);
         if4.iReady = 1'b0;
      end
   endtask

   task automatic test_random();
      int lat; logic [2:0] d; logic [1:0] g;
      logic [7:0] a, b; logic s; logic [2:0] ed; logic [1:0] eg;
      for (int i = 0; i < 200; i++) begin
         a = 8'($urandom);
         b = (i % 8 == 0) ? a : 8'($urandom);
         if (i % 5 == 0) b[7:4] = a[7:4];
         s = 1'($urandom);
         if (s) ed = ($signed(a) > $signed(b)) ? 3'b100 : ($signed(a) < $signed(b)) ? 3'b001
                                                                                       : 3'b010;
         else   ed = (a > b) ? 3'b100 : (a < b) ? 3'b001 : 3'b010;
         eg = (a[7:4] != b[7:4]) ? 2'd1 : 2'd2;
         run8(a, b, s, lat, d, g);
         checks++;
         if ({d, g, lat} !== {ed, eg, 32'(eg)}) begin
            errors++;
            $display("FAIL rnd%0d a=%h b=%h s=%b got data=%b dig=%0d lat=%0d want %b %0d %0d",
                     i, a, b, s, d, g, lat, ed, eg, eg);
         end
         repeat ($urandom_range(0, 3)) @(negedge clk);
         checks++;
         if ({if8.oValid, if8.oData, if8.oDigits} !== {1'b1, ed, eg}) begin
            errors++;
            $display("FAIL rnd_stall%0d got vld=%b data=%b dig=%0d want 1 %b %0d",
                     i, if8.oValid, if8.oData, if8.oDigits, ed, eg);
         end
         take8();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_backpressure();
      test_busy_ignore();
      test_reset_mid_op();
      test_width_eq_digit();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
